flux_scheduler: RTL
===================

Name: flux_scheduler

Overview:
- Round-robin scheduler sequencing a multi-flux SDF actor's shared datapath between FLUX competing data fluxes.
- Grants one flux at a time for a burst of BURST firings, then rotates to the next flux.
- Drives the per-port FIFO read strobes, the firing strobe and the flux tag for the actor; includes a starvation guard for stalled fluxes.

Parameters:
- FLUX, 2, number of data fluxes sharing the actor (>=1)
- PORTS, 2, input ports per flux; a flux is ready only when all its ports are non-empty
- BURST, 4, consecutive firings per grant (>=1); matches actor NUM_OP
- TIMEOUT, 8, cycles a granted flux may stall before it is abandoned; 0 disables the guard
- TAG_WIDTH, max(1,$clog2(FLUX)), width of the tag output (derived)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- en  input  1  arbitration enable; 0 blocks new grants
- empty  input  PORTS*FLUX  FIFO empty flags; bit p+f*PORTS = port p of flux f
- full  input  1  downstream FIFO full
- read  output  PORTS*FLUX  FIFO read strobes, same layout as empty
- fire  output  1  actor firing/write strobe
- tag  output  TAG_WIDTH  granted flux index
- grant_valid  output  1  a flux currently holds the grant
- burst_done  output  1  one-cycle pulse coincident with the last fire of a burst

Behaviour:
- Single clock domain: one clock clk; reset rst is synchronous and active-low (rst==0 at a posedge clk resets).
- Reset: state=IDLE, ptr=0, tag=0, burst_cnt=0, stall_cnt=0; grant_valid=0, fire=0, read=0, burst_done=0. Reset mid-burst aborts the burst immediately; no partial-burst state survives.
- ready[f] = AND over p of ~empty[p+f*PORTS].
- IDLE:
  - If en=1, full=0 and any ready[f]: pick the first ready flux scanning ptr, ptr+1, ... mod FLUX. Register tag=f, burst_cnt=BURST-1, stall_cnt=0, go BUSY.
  - No fire in IDLE. Arbitration costs exactly one cycle; the earliest fire is the cycle after the grant.
- BUSY:
  - grant_valid=1.
  - fire = ready[tag] & ~full, combinational from registered tag.
  - read[p+tag*PORTS] = fire for all p; all other read bits = 0.
  - On fire with burst_cnt==0: burst_done=1, ptr=(tag+1) mod FLUX, go IDLE.
  - On fire with burst_cnt!=0: burst_cnt decrements, stall_cnt clears.
  - No fire and TIMEOUT!=0: stall_cnt increments. When stall_cnt reaches TIMEOUT-1 without a fire, abandon: ptr=(tag+1) mod FLUX, go IDLE, burst_done stays 0.
  - en=0 in BUSY does not stop the current burst; it only blocks the next grant.
- full and ready asserted in the same cycle: no fire, counts as a stall cycle.
- Wrap-around: ptr=FLUX-1 rotates to 0. FLUX=1 always grants flux 0; rotation is a no-op.
- BURST=1: every grant yields exactly one fire, and burst_done pulses with it.
- Throughput: a sustained single ready flux gets BURST fires per BURST+1 cycles.
- The tag output holds its last value in IDLE; consumers qualify it with grant_valid.
- No output is ever X after reset. read is one-hot per flux group, and at most one flux group is active at a time.

Decomposition:
- flux_sched_pkg: state enum {IDLE,BUSY}; function tag_w(FLUX) returning max(1,$clog2(FLUX)); a counter-width helper for BURST and TIMEOUT.
- Sub-module rr_pick (combinational): inputs ready[FLUX] and ptr; outputs a valid flag and the picked index. Reused by later multi-flux actors.
- flux_scheduler owns the FSM, burst_cnt, stall_cnt, ptr and the read/fire fan-out.

Test Plan:
- Reset and release, FLUX=2, PORTS=2, all FIFOs empty -> grant_valid=0, read=0000, fire=0 for 20 cycles.
- Flux 0 and flux 1 both permanently full-of-data, full=0 -> grant tag0, 4 fires (read=0011), burst_done on the 4th; one IDLE cycle; then tag1 with 4 fires (read=1100). Strict alternation, 8 fires per 10 cycles.
- Only flux 1 has data, flux 0 with empty[0]=1 -> tag=1 is granted repeatedly; read[1:0] never asserts.
- Flux 0 granted, full held high for 8 cycles after its 2nd fire -> abandoned after TIMEOUT cycles with no burst_done; ptr=1 and flux 1 is granted next.
- en=0 during a burst -> the burst completes (all 4 fires); no new grant until en returns to 1.
- rst=0 asserted mid-burst after 2 fires -> on the next cycle grant_valid=0 and read=0; after release, flux 0 is granted first and receives a full 4-fire burst.

Source files
------------

// File: rtl/flux_sched_pkg.sv
// Shared types and width helpers for the multi-flux actor scheduler.
package flux_sched_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  // Width needed for a down-counter holding 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first ready requester at or after ptr, wrapping modulo FLUX.
module rr_pick
  import flux_sched_pkg::*;
#(
  parameter  int FLUX = 2,
  localparam int TW   = tag_w(FLUX)
) (
  input  logic [FLUX-1:0] ready,
  input  logic [TW-1:0]   ptr,
  output logic            valid,
  output logic [TW-1:0]   idx
);

  logic [FLUX-1:0] rot;
  logic [TW:0]     sum;

  // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot   = FLUX'({ready, ready} >> ptr);
    valid = |rot;
    idx   = ptr;
    sum   = '0;
    for (int k = FLUX - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (TW+1)'(k);
        if (sum >= (TW+1)'(FLUX)) sum = sum - (TW+1)'(FLUX);
        idx = TW'(sum);
      end
    end
  end

endmodule

// File: rtl/flux_scheduler.sv
// Round-robin burst scheduler sharing one SDF actor datapath between FLUX fluxes,
// with a stall guard that abandons a granted flux that stops making progress.
//
// state | meaning
// IDLE  | no grant held; arbitrating among ready fluxes
// BUSY  | tag holds the grant; firing whenever its ports are ready and output not full
module flux_scheduler
  import flux_sched_pkg::*;
#(
  parameter  int FLUX      = 2,
  parameter  int PORTS     = 2,
  parameter  int BURST     = 4,
  parameter  int TIMEOUT   = 8,
  localparam int TAG_WIDTH = tag_w(FLUX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PORTS*FLUX-1:0]  empty,
  input  logic                   full,
  output logic [PORTS*FLUX-1:0]  read,
  output logic                   fire,
  output logic [TAG_WIDTH-1:0]   tag,
  output logic                   grant_valid,
  output logic                   burst_done
);

  localparam int BW = cnt_w(BURST);
  localparam int SW = cnt_w(TIMEOUT);

  state_t               state;
  logic [TAG_WIDTH-1:0] ptr;
  logic [TAG_WIDTH-1:0] next_ptr;
  logic [TAG_WIDTH-1:0] pick_idx;
  logic                 pick_valid;
  logic [BW-1:0]        burst_cnt;
  logic [SW-1:0]        stall_cnt;
  logic [FLUX-1:0]      ready;
  logic                 last;

  always_comb begin
    ready = '0;
    for (int f = 0; f < FLUX; f++) begin
      ready[f] = ~|empty[f*PORTS +: PORTS];
    end
  end

  rr_pick #(.FLUX(FLUX)) u_pick (
    .ready (ready),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign grant_valid = (state == BUSY);
  assign fire        = grant_valid && ready[tag] && !full;
  assign last        = (burst_cnt == '0);
  assign burst_done  = fire && last;
  assign next_ptr    = (tag == TAG_WIDTH'(FLUX - 1)) ? '0 : tag + TAG_WIDTH'(1);

  always_comb begin
    read = '0;
    if (fire) read[tag*PORTS +: PORTS] = '1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      tag       <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !full && pick_valid) begin
            tag       <= pick_idx;
            burst_cnt <= BW'(BURST - 1);
            stall_cnt <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (fire) begin
            if (last) begin
              ptr   <= next_ptr;
              state <= IDLE;
            end else begin
              burst_cnt <= burst_cnt - BW'(1);
              stall_cnt <= '0;
            end
          end else if (TIMEOUT != 0) begin
            // Stalled grant: give the datapath away once the guard expires.
            if (stall_cnt == SW'(TIMEOUT - 1)) begin
              ptr   <= next_ptr;
              state <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
